gticc_common_seq: RTL

- Parametrised per-quad QPLL bring-up and supervision sequencer; one independent channel per GT quad, NQUAD channels.
- Sits between system reset/control logic and the quad QPLL common wrappers.
- Drives each QPLL reset with a guaranteed minimum pulse width, waits for lock with a timeout, and qualifies lock stability before declaring done.
- Monitors lock and refclk loss after done and re-initialises automatically, with a bounded retry budget and a sticky fail flag.

---
 rtl/gticc_common_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gticc_common_seq.sv
// +--------------------------------------------------------------------------+
// | gticc_common_seq : per-quad QPLL reset, lock qualification and recovery  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module gticc_common_seq #(
   parameter int NQUAD        = 1,
   parameter int RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int LOCK_STABLE  = 1024,
   parameter int MAX_RETRY    = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NQUAD-1:0]     qpll_lock,
   input  logic [NQUAD-1:0]     qpll_refclk_lost,
   input  logic [NQUAD-1:0]     restart,
   output logic [NQUAD-1:0]     qpll_reset,
   output logic [NQUAD-1:0]     resetdone,
   output logic [NQUAD-1:0]     fail,
   output logic [4*NQUAD-1:0]   retry_count
);

   localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
   localparam int CW    = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_DONE      = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   logic [NQUAD-1:0] lock_m, lock_s, lost_m, lost_s;
   logic [NQUAD-1:0] good;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_m <= '0;
         lock_s <= '0;
         lost_m <= '0;
         lost_s <= '0;
      end else begin
         lock_m <= qpll_lock;
         lock_s <= lock_m;
         lost_m <= qpll_refclk_lost;
         lost_s <= lost_m;
      end
   end

   assign good = lock_s & ~lost_s;

   for (genvar i = 0; i < NQUAD; i++) begin : g_ch
      state_t        state;
      logic [CW-1:0] cnt;
      logic [3:0]    retry;
      logic [3:0]    retry_inc;
      logic          qrst_q;
      logic          done_q;
      logic          fail_q;

      assign retry_inc = retry + 4'd1;

      always_ff @(posedge clk) begin
         if (reset) begin
            state  <= ST_RST;
            cnt    <= '0;
            retry  <= '0;
            qrst_q <= 1'b1;
            done_q <= 1'b0;
            fail_q <= 1'b0;
         end else if (restart[i]) begin
            // Restart overrides whatever this channel was doing, including FAIL.
            state  <= ST_RST;
            cnt    <= '0;
            retry  <= '0;
            qrst_q <= 1'b1;
            done_q <= 1'b0;
            fail_q <= 1'b0;
         end else begin
            case (state)
               ST_RST: begin
                  if (cnt == RST_LAST) begin
                     state  <= ST_WAIT_LOCK;
                     cnt    <= '0;
                     qrst_q <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (good[i]) begin
                     state <= ST_STABLE;
                     cnt   <= '0;
                  end else if (cnt == TO_LAST) begin
                     retry <= retry_inc;
                     cnt   <= '0;
                     if (retry_inc == RETRY_MAX) begin
                        state  <= ST_FAIL;
                        fail_q <= 1'b1;
                     end else begin
                        state  <= ST_RST;
                        qrst_q <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_STABLE: begin
                  if (!good[i]) begin
                     retry <= retry_inc;
                     cnt   <= '0;
                     if (retry_inc == RETRY_MAX) begin
                        state  <= ST_FAIL;
                        fail_q <= 1'b1;
                     end else begin
                        state  <= ST_RST;
                        qrst_q <= 1'b1;
                     end
                  end else if (cnt == STB_LAST) begin
                     state  <= ST_DONE;
                     cnt    <= '0;
                     done_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  // Loss after done starts a fresh acquisition counted as retry one.
                  if (!good[i]) begin
                     state  <= ST_RST;
                     cnt    <= '0;
                     retry  <= 4'd1;
                     qrst_q <= 1'b1;
                     done_q <= 1'b0;
                  end
               end
               ST_FAIL: begin
                  qrst_q <= 1'b0;
                  done_q <= 1'b0;
                  fail_q <= 1'b1;
               end
               default: begin
                  state  <= ST_RST;
                  cnt    <= '0;
                  qrst_q <= 1'b1;
                  done_q <= 1'b0;
               end
            endcase
         end
      end

      assign qpll_reset[i]          = qrst_q;
      assign resetdone[i]           = done_q;
      assign fail[i]                = fail_q;
      assign retry_count[4*i +: 4]  = retry;
   end

endmodule

`default_nettype wire
